muldiv_unit: RTL and testbench

Iterative, parametrised RV32M multiply/divide execution unit for the stall-capable next generation of the core. It sits beside the single-cycle ALU: the core forwards an M-extension operation (opcode OP, funct7 = 0000001) and its decoded funct3 plus both register operands, then stalls PC and register writeback until `done`. Width and per-cycle radix are parameters, so the same unit serves narrower test cores and faster configurations.

---
 rtl/muldiv_unit.sv | 186 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// BITS_PER_CYCLE bits retired per CALC cycle, sign fix-up in a final FIX cycle.
module muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            kill,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state, state_next;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb;

    logic              accept;
    logic              is_div_in;
    logic              sign1_in, sign2_in;
    logic              neg1, neg2, neg_in;
    logic [XLEN-1:0]   mag1, mag2;
    logic              div_zero, overflow, special;
    logic [XLEN-1:0]   special_res;

    logic [2*XLEN-1:0] step;
    logic [XLEN:0]     trial;
    logic [XLEN:0]     sum;

    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   div_sel, div_fixed, fix_res;

    // Operand decode on the request inputs; only used on the accepting edge.
    always_comb begin
        is_div_in = funct3[2];
        sign1_in  = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                    (funct3 == F_DIV)  || (funct3 == F_REM);
        sign2_in  = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
        neg1      = sign1_in & op1[XLEN-1];
        neg2      = sign2_in & op2[XLEN-1];
        mag1      = neg1 ? -op1 : op1;
        mag2      = neg2 ? -op2 : op2;
        // Remainder takes the dividend's sign; products and quotients the XOR.
        if (is_div_in && funct3[1]) begin
            neg_in = neg1;
        end else begin
            neg_in = neg1 ^ neg2;
        end
        div_zero = is_div_in && (op2 == '0);
        overflow = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                   (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
        special  = div_zero || overflow;
        if (div_zero) begin
            special_res = funct3[1] ? op1 : '1;
        end else begin
            special_res = funct3[1] ? '0 : op1;
        end
    end

    always_comb begin
        ready = (state == IDLE) || (state == DONE);
        busy  = (state == CALC) || (state == FIX);
        done  = (state == DONE);
    end

    assign accept = ready && start && !kill;

    // One CALC cycle: acc holds {product high, multiplier} for multiply
    // and {remainder, dividend/quotient} for divide.
    always_comb begin
        step  = acc;
        trial = '0;
        sum   = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (op_q[2]) begin
                trial = {step[2*XLEN-1:XLEN], step[XLEN-1]} - {1'b0, opb};
                if (!trial[XLEN]) begin
                    step = {trial[XLEN-1:0], step[XLEN-2:0], 1'b1};
                end else begin
                    step = {step[2*XLEN-2:0], 1'b0};
                end
            end else begin
                sum  = {1'b0, step[2*XLEN-1:XLEN]} + (step[0] ? {1'b0, opb} : '0);
                step = {sum, step[XLEN-1:1]};
            end
        end
    end

    always_comb begin
        prod_fixed = neg_q ? -acc : acc;
        div_sel    = op_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        div_fixed  = neg_q ? -div_sel : div_sel;
        if (op_q[2]) begin
            fix_res = div_fixed;
        end else if (op_q == F_MUL) begin
            fix_res = prod_fixed[XLEN-1:0];
        end else begin
            fix_res = prod_fixed[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (kill) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_next = special ? DONE : CALC;
                    end else begin
                        state_next = IDLE;
                    end
                end
                CALC: begin
                    if (cnt == CNT_LAST) begin
                        state_next = FIX;
                    end
                end
                FIX:     state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= '0;
            neg_q  <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            result <= '0;
        end else if (!kill) begin
            if (accept) begin
                op_q  <= funct3;
                neg_q <= neg_in;
                cnt   <= '0;
                if (special) begin
                    result <= special_res;
                end else if (is_div_in) begin
                    acc <= {{XLEN{1'b0}}, mag1};
                    opb <= mag2;
                end else begin
                    acc <= {{XLEN{1'b0}}, mag2};
                    opb <= mag1;
                end
            end else if (state == CALC) begin
                acc <= step;
                cnt <= cnt + CNT_W'(1);
            end else if (state == FIX) begin
                result <= fix_res;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: runs the same vectors on a radix-1 and a
// radix-4 instance, checking results, latency, kill, reset and back-to-back.
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic [1:0]           start_v, kill_v, ready_v, busy_v, done_v;
    logic [1:0][2:0]      funct3_v;
    logic [1:0][XLEN-1:0] op1_v, op2_v, result_v;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]      f;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
        bit              special;
    } vec_t;

    vec_t vecs[$];

    muldiv_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(1)) u_dut_r1 (
        .clk(clk), .reset(reset), .start(start_v[0]), .funct3(funct3_v[0]),
        .op1(op1_v[0]), .op2(op2_v[0]), .kill(kill_v[0]),
        .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]), .result(result_v[0])
    );

    muldiv_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(4)) u_dut_r4 (
        .clk(clk), .reset(reset), .start(start_v[1]), .funct3(funct3_v[1]),
        .op1(op1_v[1]), .op2(op2_v[1]), .kill(kill_v[1]),
        .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]), .result(result_v[1])
    );

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int n_of(input int sel);
        return (sel == 0) ? 32 : 8;
    endfunction

    task automatic add_vec(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [XLEN-1:0] e, input bit sp);
        vec_t v;
        v.f = f; v.a = a; v.b = b; v.exp = e; v.special = sp;
        vecs.push_back(v);
    endtask

    task automatic wait_done(input int sel);
        int n = 0;
        while (!done_v[sel] && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic drive(input int sel, input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        funct3_v[sel] = f;
        op1_v[sel]    = a;
        op2_v[sel]    = b;
    endtask

    task automatic run_op(input int sel, input int idx);
        string       tag;
        vec_t        v;
        int unsigned t0;
        v   = vecs[idx];
        tag = $sformatf("r%0d_v%0d_f%0d", sel, idx, v.f);
        check({tag, "_ready"}, ready_v[sel], 1);
        drive(sel, v.f, v.a, v.b);
        start_v[sel] = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_v[sel] = 1'b0;
        wait_done(sel);
        check({tag, "_lat"}, cyc - t0 - 1, v.special ? 0 : n_of(sel) + 1);
        check({tag, "_res"}, result_v[sel], v.exp);
        @(negedge clk);
        check({tag, "_pulse"}, done_v[sel], 0);
    endtask

    task automatic kill_reset_test(input int sel, input logic [XLEN-1:0] prev);
        string tag;
        bit    seen;
        tag = $sformatf("r%0d", sel);
        drive(sel, 3'b101, 32'd100, 32'd7);
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        repeat ((sel == 0) ? 10 : 5) @(negedge clk);
        check({tag, "_kill_busy_before"}, busy_v[sel], 1);
        kill_v[sel] = 1'b1;
        @(negedge clk);
        kill_v[sel] = 1'b0;
        check({tag, "_kill_busy"}, busy_v[sel], 0);
        check({tag, "_kill_ready"}, ready_v[sel], 1);
        check({tag, "_kill_res"}, result_v[sel], prev);
        seen = 1'b0;
        repeat (n_of(sel) + 4) begin
            if (done_v[sel]) seen = 1'b1;
            @(negedge clk);
        end
        check({tag, "_kill_nodone"}, seen, 0);

        // Special-case request with kill: would otherwise complete immediately.
        drive(sel, 3'b101, 32'd100, 32'd0);
        start_v[sel] = 1'b1;
        kill_v[sel]  = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        kill_v[sel]  = 1'b0;
        check({tag, "_sk_done"}, done_v[sel], 0);
        check({tag, "_sk_busy"}, busy_v[sel], 0);
        check({tag, "_sk_res"}, result_v[sel], prev);

        drive(sel, 3'b000, 32'd3, 32'd5);
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        repeat (4) @(negedge clk);
        check({tag, "_rst_busy_before"}, busy_v[sel], 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check({tag, "_rst_res"}, result_v[sel], 0);
        check({tag, "_rst_ready"}, ready_v[sel], 1);
        check({tag, "_rst_busy"}, busy_v[sel], 0);
        seen = 1'b0;
        repeat (n_of(sel) + 4) begin
            if (done_v[sel]) seen = 1'b1;
            @(negedge clk);
        end
        check({tag, "_rst_nodone"}, seen, 0);
    endtask

    task automatic b2b_test(input int sel);
        string       tag;
        int unsigned t0, t1;
        tag = $sformatf("r%0d_b2b", sel);
        drive(sel, 3'b000, 32'd3, 32'd5);
        start_v[sel] = 1'b1;
        t0 = cyc;
        @(negedge clk);
        drive(sel, 3'b101, 32'd100, 32'd7);
        wait_done(sel);
        check({tag, "_lat1"}, cyc - t0 - 1, n_of(sel) + 1);
        check({tag, "_res1"}, result_v[sel], 32'd15);
        t1 = cyc;
        @(negedge clk);
        check({tag, "_accept2"}, busy_v[sel], 1);
        check({tag, "_nodbl"}, done_v[sel], 0);
        start_v[sel] = 1'b0;
        repeat (2) @(negedge clk);
        drive(sel, 3'b101, 32'd100, 32'd0);
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        check({tag, "_ignored"}, busy_v[sel], 1);
        wait_done(sel);
        check({tag, "_lat2"}, cyc - t1 - 1, n_of(sel) + 1);
        check({tag, "_res2"}, result_v[sel], 32'd14);
        @(negedge clk);
        check({tag, "_pulse2"}, done_v[sel], 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        add_vec(3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        add_vec(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        add_vec(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        add_vec(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        add_vec(3'b010, 32'd2,         32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        add_vec(3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0);
        add_vec(3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0);
        add_vec(3'b001, 32'hFFFF_FFFF, 32'd5,         32'hFFFF_FFFF, 1'b0);
        add_vec(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
        add_vec(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0);
        add_vec(3'b101, 32'd100,       32'd7,         32'd14,        1'b0);
        add_vec(3'b111, 32'd100,       32'd7,         32'd2,         1'b0);
        add_vec(3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        add_vec(3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0);
        add_vec(3'b101, 32'd7,         32'd100,       32'd0,         1'b0);
        add_vec(3'b100, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0);
        add_vec(3'b101, 32'd100,       32'd0,         32'hFFFF_FFFF, 1'b1);
        add_vec(3'b110, 32'd100,       32'd0,         32'd100,       1'b1);
        add_vec(3'b111, 32'd5,         32'd0,         32'd5,         1'b1);
        add_vec(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1);
        add_vec(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);

        reset    = 1'b1;
        start_v  = '0;
        kill_v   = '0;
        funct3_v = '0;
        op1_v    = '0;
        op2_v    = '0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("r%0d_reset_res", s),   result_v[s], 0);
            check($sformatf("r%0d_reset_done", s),  done_v[s],   0);
            check($sformatf("r%0d_reset_busy", s),  busy_v[s],   0);
            check($sformatf("r%0d_reset_ready", s), ready_v[s],  1);
        end
        reset = 1'b0;
        @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < vecs.size(); i++) begin
                run_op(s, i);
            end
            kill_reset_test(s, vecs[vecs.size() - 1].exp);
            b2b_test(s);
            repeat (2) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
